ps2_host_rx: RTL

- PS/2 host-side receiver. Decodes the keyboard serial stream produced by user_io (ps2_kbd_clk / ps2_kbd_data) into bytes.
- Buffers received bytes in a small FIFO that the terminal subsystem's keyboard controller pops.
- Runs entirely in the clk_p (100 MHz) domain.
- PS/2 lines are treated as asynchronous inputs. They are synchronised and filtered inside the block.

---
 rtl/ps2_host_rx.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_rx
// Brief    : PS/2 host-side receiver. Synchronises and filters the PS/2
//            clock/data lines, decodes 11-bit frames (start, 8 data LSB
//            first, odd parity, stop) and queues good bytes in a small FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_host_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 100000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_p,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rx_rd,
  output logic [7:0] rx_data,
  output logic       rx_empty,
  output logic       rx_err,
  output logic       rx_ovf,
  input  logic       ovf_clr,
  output logic       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [7:0]    c_FILT_LAST = 8'(FILTER_LEN - 1);
  localparam logic [TW-1:0] c_TO_LAST   = TW'(TIMEOUT - 1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_DATA   = 2'd1;
  localparam logic [1:0] c_PARITY = 2'd2;
  localparam logic [1:0] c_STOP   = 2'd3;

  // Input conditioning state
  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic [7:0]    clk_cnt_q, clk_cnt_d, dat_cnt_q, dat_cnt_d;
  logic          clk_filt_q, clk_filt_d, dat_filt_q, dat_filt_d;
  logic          clk_prev_q, clk_prev_d;

  // Frame decoder state
  logic [1:0]    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d;

  // FIFO state
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
  logic          ovf_q, ovf_d;

  logic          w_fe;
  logic          w_bit;
  logic          w_push;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_wr_en;

  // Two-stage synchronisers, then a saturating run-length filter per line:
  // the filtered level only follows the input after FILTER_LEN consecutive
  // samples disagree with it.
  always_comb begin
    clk_s1_d   = ps2_clk;
    clk_s2_d   = clk_s1_q;
    dat_s1_d   = ps2_data;
    dat_s2_d   = dat_s1_q;
    clk_prev_d = clk_filt_q;

    clk_cnt_d  = '0;
    clk_filt_d = clk_filt_q;
    if (clk_s2_q != clk_filt_q) begin
      if (clk_cnt_q == c_FILT_LAST) begin
        clk_filt_d = clk_s2_q;
      end else begin
        clk_cnt_d = clk_cnt_q + 8'd1;
      end
    end

    dat_cnt_d  = '0;
    dat_filt_d = dat_filt_q;
    if (dat_s2_q != dat_filt_q) begin
      if (dat_cnt_q == c_FILT_LAST) begin
        dat_filt_d = dat_s2_q;
      end else begin
        dat_cnt_d = dat_cnt_q + 8'd1;
      end
    end
  end

  // Falling edge of the filtered clock; data is taken at the same instant.
  assign w_fe  = clk_prev_q & ~clk_filt_q;
  assign w_bit = dat_filt_q;

  // Frame decoder: start/data/parity/stop sequencing plus inter-edge timeout.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    timer_d   = '0;
    err_d     = 1'b0;
    w_push    = 1'b0;

    if (state_q != c_IDLE) begin
      timer_d = w_fe ? '0 : timer_q + TW'(1);
    end

    case (state_q)
      c_IDLE: begin
        if (w_fe) begin
          if (!w_bit) begin
            state_d   = c_DATA;
            bit_cnt_d = 3'd0;
            timer_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      c_DATA: begin
        if (w_fe) begin
          shift_d   = {w_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = c_PARITY;
          end
        end
      end
      c_PARITY: begin
        if (w_fe) begin
          par_d   = w_bit;
          state_d = c_STOP;
        end
      end
      c_STOP: begin
        if (w_fe) begin
          // Odd parity: the XOR over data and parity must be 1.
          if (w_bit && (^{shift_q, par_q})) begin
            w_push = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = c_IDLE;
        end
      end
      default: state_d = c_IDLE;
    endcase

    // A stalled frame is abandoned; the partial byte is simply never pushed.
    if ((state_q != c_IDLE) && !w_fe && (timer_q == c_TO_LAST)) begin
      err_d   = 1'b1;
      state_d = c_IDLE;
      timer_d = '0;
    end
  end

  // FIFO bookkeeping: extra pointer bit separates full from empty; a full
  // FIFO still accepts a push when a pop frees the head slot that cycle.
  always_comb begin
    w_empty = (wr_q == rd_q);
    w_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    w_pop   = rx_rd & ~w_empty;
    w_wr_en = w_push & (~w_full | w_pop);

    mem_d = mem_q;
    if (w_wr_en) begin
      mem_d[wr_q[AW-1:0]] = shift_q;
    end
    wr_d = wr_q + (AW+1)'(w_wr_en);
    rd_d = rd_q + (AW+1)'(w_pop);

    if (w_push && w_full && !w_pop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers; the idle PS/2 bus level is high, so line state resets to 1.
  always_ff @(posedge clk_p) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      clk_cnt_q  <= '0;
      dat_cnt_q  <= '0;
      clk_filt_q <= 1'b1;
      dat_filt_q <= 1'b1;
      clk_prev_q <= 1'b1;
      state_q    <= c_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      timer_q    <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q       <= '0;
      rd_q       <= '0;
      ovf_q      <= 1'b0;
    end else begin
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      clk_cnt_q  <= clk_cnt_d;
      dat_cnt_q  <= dat_cnt_d;
      clk_filt_q <= clk_filt_d;
      dat_filt_q <= dat_filt_d;
      clk_prev_q <= clk_prev_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
      mem_q      <= mem_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      ovf_q      <= ovf_d;
    end
  end

  assign rx_data  = mem_q[rd_q[AW-1:0]];
  assign rx_empty = w_empty;
  assign rx_err   = err_q;
  assign rx_ovf   = ovf_q;
  assign busy     = (state_q != c_IDLE);

endmodule
`default_nettype wire
